// File: rtl/uart_word_rx.sv
// UART receiver that assembles BYTE_NUM consecutive bytes into one word and
// hands the word over a valid/ready handshake. It reports parity, framing,
// inter-byte gap timeout and overrun errors as single-cycle pulses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for a synchronised falling edge
// START | inside the start bit; a high level at mid-bit is a glitch
// DATA  | shifting in 8 data bits, LSB first, sampled at mid-bit
// PAR   | sampling the parity bit (only when PARITY != 0)
// STOP  | stop bit; decision made at mid-bit, then straight back to IDLE
module uart_word_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int UART_BPS     = 9600,
    parameter int BYTE_NUM     = 2,
    parameter int PARITY       = 0,
    parameter int LSB_BYTE_1ST = 1,
    parameter int GAP_BITS     = 20,
    localparam int DATAWIDTH   = 8 * BYTE_NUM
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic [DATAWIDTH-1:0] word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 gap_err,
    output logic                 overrun
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int GAP_CYC = GAP_BITS * BPS_CNT;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam int IDX_W   = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 rxd_s1, rxd_s2, rxd_d;
    logic [CNT_W-1:0]     bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           rx_byte;
    logic                 par_bad;
    logic [IDX_W-1:0]     byte_idx;
    logic [DATAWIDTH-1:0] word_buf, word_new;
    logic [GAP_W-1:0]     gap_cnt;

    logic start_edge, mid_bit, end_bit, stop_done, byte_ok, word_done;
    logic gap_fire, exp_par;

    assign start_edge = rxd_d & ~rxd_s2;
    assign mid_bit    = (bit_cnt == CNT_W'(HALF));
    assign end_bit    = (bit_cnt == CNT_W'(BPS_CNT - 1));
    assign stop_done  = (state == STOP) && mid_bit;
    assign byte_ok    = stop_done && rxd_s2 && !par_bad;
    assign word_done  = byte_ok && (byte_idx == IDX_W'(BYTE_NUM - 1));
    assign gap_fire   = (state == IDLE) && (byte_idx != '0) && (gap_cnt == '0);
    // odd parity: data plus parity bit carry an odd number of ones
    assign exp_par    = (PARITY == 1) ? ~^rx_byte : ^rx_byte;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle high
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_edge) state_nxt = START;
            START: begin
                if (mid_bit && rxd_s2) state_nxt = IDLE;
                else if (end_bit)      state_nxt = DATA;
            end
            DATA:  if (end_bit && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (end_bit) state_nxt = STOP;
            STOP:  if (mid_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current byte dropped into its slot of the word being assembled
    always_comb begin
        word_new = word_buf;
        for (int i = 0; i < BYTE_NUM; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                if (LSB_BYTE_1ST != 0) word_new[8*i +: 8] = rx_byte;
                else                   word_new[8*(BYTE_NUM-1-i) +: 8] = rx_byte;
            end
        end
    end

    // Bit timer, bit index, data shift register and parity check
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
            par_bad <= 1'b0;
        end else begin
            // IDLE holds the timer at zero so START begins counting from 0
            if (state == IDLE || end_bit) bit_cnt <= '0;
            else                          bit_cnt <= bit_cnt + 1'b1;
            if (state != DATA)  bit_idx <= '0;
            else if (end_bit)   bit_idx <= bit_idx + 1'b1;
            if (state == DATA && mid_bit) rx_byte <= {rxd_s2, rx_byte[7:1]};
            if (state == IDLE)                 par_bad <= 1'b0;
            else if (state == PAR && mid_bit)  par_bad <= rxd_s2 ^ exp_par;
        end
    end

    // Byte acceptance, word delivery, error pulses and gap timeout
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_idx   <= '0;
            word_buf   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            gap_err    <= 1'b0;
            overrun    <= 1'b0;
            gap_cnt    <= GAP_W'(GAP_CYC - 1);
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            gap_err    <= 1'b0;
            overrun    <= 1'b0;

            if (stop_done) begin
                // a low stop bit masks any parity problem in the same byte
                if (!rxd_s2) begin
                    frame_err <= 1'b1;
                    byte_idx  <= '0;
                end else if (par_bad) begin
                    parity_err <= 1'b1;
                    byte_idx   <= '0;
                end else begin
                    word_buf <= word_new;
                    byte_idx <= word_done ? '0 : byte_idx + 1'b1;
                end
            end else if (gap_fire) begin
                gap_err  <= 1'b1;
                byte_idx <= '0;
            end

            // gap timer only runs while a partial word waits in IDLE
            if (state != IDLE || byte_idx == '0) gap_cnt <= GAP_W'(GAP_CYC - 1);
            else if (gap_cnt != '0)              gap_cnt <= gap_cnt - 1'b1;

            // a word accepted in the same cycle frees the slot for the new one
            if (word_done) begin
                if (word_valid && !word_ready) begin
                    overrun <= 1'b1;
                end else begin
                    word_data  <= word_new;
                    word_valid <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule
